alu_seq: RTL and testbench
==========================

# alu_seq

Parametrised, multi-cycle successor to the tiny16 combinational ALU. Single-cycle ops (add, sub, logic, shifts) complete in one cycle; multiply and divide run iteratively, one bit per cycle (shift-add and restoring divide). A start/busy/done handshake connects it to the control unit. The block adds registered results, a high-half output (product high / remainder), per-op carry semantics and a divide-by-zero indication. It sits between the register-file read ports and the write-back mux.

## Interface
- WIDTH, 16, datapath width in bits; legal range WIDTH >= 4.
- clk  in  1  clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  request; sampled only when busy=0.
- opcode  in  4  operation select (encoding below).
- ar_flag  in  1  arithmetic (1) or logical (0) shift select.
- src1  in  WIDTH  operand A / dividend.
- src2  in  WIDTH  operand B / divisor / shift amount (unsigned).
- busy  out  1  a MUL/DIV is in progress.
- done  out  1  one-cycle pulse; out, out_hi, flags and dz were updated at the same edge.
- out  out  WIDTH  result (low half / quotient).
- out_hi  out  WIDTH  product high half (MUL) or remainder (DIV); 0 for all other ops.
- flags  out  4  {O, C, N, Z}.
- dz  out  1  last DIV had src2 == 0.

## Operation
- Opcodes:
  - 0011 ADD, 0100 SUB, 0101 MUL (unsigned), 0110 DIV (unsigned).
  - 0111 AND, 1000 OR, 1001 XOR, 1010 SHL, 1011 SHR.
  - All other codes are NOP: out=0, out_hi=0, flags=0001, dz=0.
- States: IDLE, ITER, FINISH.
  - IDLE + start + single-cycle op: result is computed from the live inputs and written at the sampling edge; done=1 for the next cycle; stay in IDLE.
  - IDLE + start + MUL/DIV: latch src1 and src2, clear the accumulator, set counter to WIDTH, go to ITER; busy=1.
  - ITER: one iteration per cycle; decrement counter; at 0 go to FINISH.
  - FINISH: write outputs, pulse done, clear busy, go to IDLE.
- start while busy=1 is ignored. Operand changes during ITER have no effect, because operands are latched.
- Outputs hold their value until the next completion.
- Flags are computed on the final WIDTH-bit out:
  - N = out[WIDTH-1].
  - Z = (out == 0).
  - O:
    - ADD: operands have the same sign and the result sign differs.
    - SUB: operand signs differ and the result sign differs from src1.
    - All other ops: 0.
  - C:
    - ADD: carry out.
    - SUB: borrow (src1 < src2, unsigned).
    - MUL: out_hi != 0.
    - SHL/SHR: last bit shifted out, or 0 if the shift amount is 0.
    - Logic, DIV: 0.
- Shifts:
  - Amount is the full src2 value. If src2 >= WIDTH, the result is 0; the exception is arithmetic SHR, which gives all copies of src1[WIDTH-1].
  - C is 0 when src2 > WIDTH.
  - SHL ignores ar_flag.
- DIV by zero runs the full restoring sequence: quotient = all ones, remainder = src1, dz=1. dz is cleared by any other completed op.

## Timing
- Reset (rst=1 at an edge) sets: state IDLE, busy=0, done=0, out=0, out_hi=0, flags=0000, dz=0.
  - This applies mid-operation: the op is abandoned and no done pulse is issued.
  - start is ignored in a cycle where rst=1.
- Single-cycle latency: start sampled at edge k -> outputs and done visible after edge k.
- MUL/DIV latency:
  - start at edge k -> busy high after k.
  - WIDTH iterations at edges k+1 .. k+WIDTH.
  - FINISH at edge k+WIDTH+1 -> outputs and done, busy low.
  - Next start is accepted at edge k+WIDTH+2 at the earliest. Back-to-back single-cycle ops are accepted every cycle.
- done is never high for two consecutive cycles from one request.

## Test plan
All scenarios use WIDTH=16.
- ADD 0x7FFF + 0x0001 -> out 0x8000, flags 1010, done one cycle after start, busy stays 0.
- SUB 0x0001 − 0x0002 -> out 0xFFFF, flags 0110. AND 0x00F0 & 0x0F00 -> out 0x0000, flags 0001.
- MUL 0x1234 × 0x0100 -> busy for 17 cycles, done after edge k+17, out 0x3400, out_hi 0x0012, C=1. A start pulsed mid-run is ignored.
- DIV 100 / 7 -> out 14, out_hi 2, dz=0. DIV 0x00AB / 0 -> out 0xFFFF, out_hi 0x00AB, dz=1. A following ADD clears dz.
- SHR ar_flag=1 0x8000 by 20 -> out 0xFFFF, C=0. SHR ar_flag=0 0x8001 by 1 -> out 0x4000, C=1. SHL 0x8000 by 1 -> out 0, flags 0101.
- rst asserted at the 5th ITER cycle of a DIV:
  - busy=0, out=0, flags=0000, no done.
  - A new ADD issued the next cycle completes normally.

Source files
------------

// File: rtl/alu_seq.sv
// Multi-cycle ALU: single-cycle add/sub/logic/shift ops plus iterative
// shift-add multiply and restoring divide behind a start/busy/done handshake.
module alu_seq #(
  parameter int unsigned WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [3:0]       opcode,
  input  logic             ar_flag,
  input  logic [WIDTH-1:0] src1,
  input  logic [WIDTH-1:0] src2,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] out,
  output logic [WIDTH-1:0] out_hi,
  output logic [3:0]       flags,
  output logic             dz
);

  typedef enum logic [1:0] {IDLE, ITER, FINISH} state_t;
  typedef enum logic [3:0] {
    OP_ADD = 4'd3, OP_SUB, OP_MUL, OP_DIV, OP_AND, OP_OR, OP_XOR, OP_SHL, OP_SHR
  } op_t;

  localparam int unsigned      CW         = $clog2(WIDTH + 1);
  localparam logic [CW-1:0]    COUNT_INIT = CW'(WIDTH);
  localparam logic [WIDTH-1:0] W_AMT      = WIDTH'(WIDTH);

  state_t state, state_next;
  logic [CW-1:0]    count;
  logic [WIDTH-1:0] acc, lo, opnd;
  logic             is_div;
  logic             iter_op;

  logic [WIDTH:0]   mul_sum, div_shift, div_trial;
  logic [WIDTH-1:0] acc_next, lo_next;

  logic [WIDTH:0]   add_w, sub_w, shl_w, shr_w;
  logic [WIDTH-1:0] res_out, res_hi;
  logic             res_o, res_c;

  assign iter_op = (opcode == OP_MUL) || (opcode == OP_DIV);
  assign busy    = (state != IDLE);

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_next;
  end

  always_comb begin
    state_next = state;
    unique case (state)
      IDLE:    if (start && iter_op) state_next = ITER;
      ITER:    if (count == CW'(1)) state_next = FINISH;
      FINISH:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // acc:lo forms the double-width shift register for both algorithms:
  // product high:low for MUL, partial remainder:quotient/dividend for DIV.
  always_comb begin
    mul_sum   = lo[0] ? ({1'b0, acc} + {1'b0, opnd}) : {1'b0, acc};
    div_shift = {acc, lo[WIDTH-1]};
    div_trial = div_shift - {1'b0, opnd};
    if (is_div) begin
      if (div_shift >= {1'b0, opnd}) begin
        acc_next = div_trial[WIDTH-1:0];
        lo_next  = {lo[WIDTH-2:0], 1'b1};
      end else begin
        acc_next = div_shift[WIDTH-1:0];
        lo_next  = {lo[WIDTH-2:0], 1'b0};
      end
    end else begin
      acc_next = mul_sum[WIDTH:1];
      lo_next  = {mul_sum[0], lo[WIDTH-1:1]};
    end
  end

  always_comb begin
    add_w   = {1'b0, src1} + {1'b0, src2};
    sub_w   = {1'b0, src1} - {1'b0, src2};
    shl_w   = {1'b0, src1} << src2;
    if (ar_flag) shr_w = $signed({src1, 1'b0}) >>> src2;
    else         shr_w = {src1, 1'b0} >> src2;
    res_out = '0;
    res_hi  = '0;
    res_o   = 1'b0;
    res_c   = 1'b0;
    if (state == FINISH) begin
      res_out = lo;
      res_hi  = acc;
      res_c   = !is_div && (acc != '0);
    end else begin
      case (opcode)
        OP_ADD: begin
          res_out = add_w[WIDTH-1:0];
          res_c   = add_w[WIDTH];
          res_o   = (src1[WIDTH-1] == src2[WIDTH-1]) && (add_w[WIDTH-1] != src1[WIDTH-1]);
        end
        OP_SUB: begin
          res_out = sub_w[WIDTH-1:0];
          res_c   = sub_w[WIDTH];
          res_o   = (src1[WIDTH-1] != src2[WIDTH-1]) && (sub_w[WIDTH-1] != src1[WIDTH-1]);
        end
        OP_AND: res_out = src1 & src2;
        OP_OR:  res_out = src1 | src2;
        OP_XOR: res_out = src1 ^ src2;
        // The extra bit of the widened shift captures the last bit shifted out.
        OP_SHL: begin
          if (src2 <= W_AMT) begin
            res_out = shl_w[WIDTH-1:0];
            res_c   = shl_w[WIDTH];
          end
        end
        OP_SHR: begin
          if (src2 <= W_AMT) begin
            res_out = shr_w[WIDTH:1];
            res_c   = shr_w[0];
          end else if (ar_flag) begin
            res_out = {WIDTH{src1[WIDTH-1]}};
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      done   <= 1'b0;
      out    <= '0;
      out_hi <= '0;
      flags  <= '0;
      dz     <= 1'b0;
      acc    <= '0;
      lo     <= '0;
      opnd   <= '0;
      is_div <= 1'b0;
      count  <= '0;
    end else begin
      done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            if (iter_op) begin
              acc    <= '0;
              lo     <= src1;
              opnd   <= src2;
              is_div <= (opcode == OP_DIV);
              count  <= COUNT_INIT;
            end else begin
              out    <= res_out;
              out_hi <= res_hi;
              flags  <= {res_o, res_c, res_out[WIDTH-1], res_out == '0};
              dz     <= 1'b0;
              done   <= 1'b1;
            end
          end
        end
        ITER: begin
          acc   <= acc_next;
          lo    <= lo_next;
          count <= count - CW'(1);
        end
        FINISH: begin
          out    <= res_out;
          out_hi <= res_hi;
          flags  <= {res_o, res_c, res_out[WIDTH-1], res_out == '0};
          dz     <= is_div && (opnd == '0);
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_alu_seq.sv
// Self-checking bench for alu_seq: directed scenarios plus randomized ops
// compared against an arithmetic reference model.
module tb_alu_seq;
  localparam int W = 16;

  logic         clk = 1'b0;
  logic         rst, start, ar_flag;
  logic [3:0]   opcode;
  logic [W-1:0] src1, src2;
  logic         busy, done, dz;
  logic [W-1:0] out, out_hi;
  logic [3:0]   flags;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  alu_seq #(.WIDTH(W)) dut (
    .clk(clk), .rst(rst), .start(start), .opcode(opcode), .ar_flag(ar_flag),
    .src1(src1), .src2(src2), .busy(busy), .done(done), .out(out),
    .out_hi(out_hi), .flags(flags), .dz(dz)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic void model(input logic [3:0] op, input logic [W-1:0] a, b,
                                input logic ar, output logic [W-1:0] o, hi,
                                output logic [3:0] f, output logic z);
    longint ua, ub, p;
    int sa, sb, r;
    logic ov, c;
    ua = a; ub = b;
    sa = $signed(a); sb = $signed(b);
    o = '0; hi = '0; ov = 1'b0; c = 1'b0; z = 1'b0;
    case (op)
      4'd3: begin
        o = W'(ua + ub); c = (ua + ub) >= (64'd1 << W);
        r = sa + sb; ov = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
      end
      4'd4: begin
        o = W'(ua - ub); c = ua < ub;
        r = sa - sb; ov = (r > (1 << (W-1)) - 1) || (r < -(1 << (W-1)));
      end
      4'd5: begin
        p = ua * ub; o = W'(p); hi = W'(p >> W); c = (hi != '0);
      end
      4'd6: begin
        if (ub == 0) begin o = '1; hi = a; z = 1'b1; end
        else begin o = W'(ua / ub); hi = W'(ua % ub); end
      end
      4'd7: o = a & b;
      4'd8: o = a | b;
      4'd9: o = a ^ b;
      4'd10: begin
        if (ub == 0) o = a;
        else if (ub <= W) begin o = W'(ua << ub); c = ((ua >> (W - ub)) & 1) != 0; end
      end
      4'd11: begin
        if (ub == 0) o = a;
        else if (ub <= W) begin
          o = ar ? W'(sa >>> ub) : W'(ua >> ub);
          c = ((ua >> (ub - 1)) & 1) != 0;
        end else o = ar ? {W{a[W-1]}} : '0;
      end
      default: ;
    endcase
    f = {ov, c, o[W-1], o == '0};
  endfunction

  task automatic run_op(input logic [3:0] op, input logic [W-1:0] a, b,
                        input logic ar, input bit disturb);
    logic [W-1:0] eo, eh;
    logic [3:0]   ef;
    logic         ez;
    int           n;
    model(op, a, b, ar, eo, eh, ef, ez);
    opcode = op; src1 = a; src2 = b; ar_flag = ar; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    if (op != 4'd5 && op != 4'd6) begin
      check("sc_done", done, 1);
      check("sc_busy", busy, 0);
    end else begin
      check("mc_busy", busy, 1);
      check("mc_done_early", done, 0);
      n = 0;
      while (!done && n < 4*W) begin
        if (disturb && n == 5) begin
          start = 1'b1; opcode = 4'd3; src1 = W'($urandom); src2 = W'($urandom);
        end else if (disturb) begin
          start = 1'b0; src1 = W'($urandom); src2 = W'($urandom);
        end
        @(posedge clk); #1;
        n++;
      end
      start = 1'b0;
      check("mc_latency", n, W + 1);
      check("mc_busy_end", busy, 0);
    end
    check("out", out, eo);
    check("out_hi", out_hi, eh);
    check("flags", flags, ef);
    check("dz", dz, ez);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int seen;
    logic [3:0] op;
    logic [W-1:0] a, b;
    rst = 1'b1; start = 1'b0; opcode = '0; src1 = '0; src2 = '0; ar_flag = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);   check("rst_done", done, 0);
    check("rst_out", out, 0);     check("rst_hi", out_hi, 0);
    check("rst_flags", flags, 0); check("rst_dz", dz, 0);
    rst = 1'b0;

    run_op(4'd3, 16'h7FFF, 16'h0001, 1'b0, 1'b0);
    check("add_out_const", out, 16'h8000);
    check("add_flags_const", flags, 4'b1010);
    @(posedge clk); #1;
    check("done_pulse_drop", done, 0);

    run_op(4'd4, 16'h0001, 16'h0002, 1'b0, 1'b0);
    check("sub_flags_const", flags, 4'b0110);
    run_op(4'd7, 16'h00F0, 16'h0F00, 1'b0, 1'b0);
    check("and_flags_const", flags, 4'b0001);

    run_op(4'd5, 16'h1234, 16'h0100, 1'b0, 1'b1);
    check("mul_hi_const", out_hi, 16'h0012);
    @(posedge clk); #1;
    check("mul_no_second_done", done, 0);
    check("mul_no_restart", busy, 0);

    run_op(4'd6, 16'd100, 16'd7, 1'b0, 1'b0);
    run_op(4'd6, 16'h00AB, 16'h0000, 1'b0, 1'b0);
    check("dz_set_const", dz, 1);
    run_op(4'd3, 16'h0001, 16'h0001, 1'b0, 1'b0);
    check("dz_clear_const", dz, 0);

    run_op(4'd11, 16'h8000, 16'd20, 1'b1, 1'b0);
    run_op(4'd11, 16'h8001, 16'd1, 1'b0, 1'b0);
    run_op(4'd10, 16'h8000, 16'd1, 1'b0, 1'b0);
    check("shl_flags_const", flags, 4'b0101);
    run_op(4'd10, 16'h0001, 16'd16, 1'b1, 1'b0);
    run_op(4'd11, 16'h8000, 16'd16, 1'b0, 1'b0);
    run_op(4'd11, 16'h8000, 16'd16, 1'b1, 1'b0);
    run_op(4'd10, 16'hFFFF, 16'd17, 1'b0, 1'b0);
    run_op(4'd11, 16'h1234, 16'd0, 1'b1, 1'b0);
    run_op(4'd0, 16'h0005, 16'h0005, 1'b0, 1'b0);
    run_op(4'd15, 16'hFFFF, 16'hFFFF, 1'b1, 1'b0);

    opcode = 4'd6; src1 = 16'd1000; src2 = 16'd3; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    rst = 1'b1; start = 1'b1; opcode = 4'd3; src1 = 16'd1; src2 = 16'd1;
    @(posedge clk); #1;
    rst = 1'b0; start = 1'b0;
    check("midrst_busy", busy, 0);   check("midrst_done", done, 0);
    check("midrst_out", out, 0);     check("midrst_hi", out_hi, 0);
    check("midrst_flags", flags, 0); check("midrst_dz", dz, 0);
    run_op(4'd3, 16'h0005, 16'h0006, 1'b0, 1'b0);
    seen = 0;
    repeat (2*W) begin
      @(posedge clk); #1;
      if (done || busy) seen++;
    end
    check("no_stray_done", seen, 0);

    repeat (300) begin
      op = 4'($urandom_range(0, 15));
      a  = W'($urandom);
      b  = $urandom_range(0, 1) ? W'($urandom) : W'($urandom_range(0, 20));
      run_op(op, a, b, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));
      if ($urandom_range(0, 3) == 0) begin
        @(posedge clk); #1;
      end
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
